amm_mem_responder: RTL and testbench

//   Avalon-MM burst slave that answers the memory checker's traffic generator.
//   It stores write bursts in an internal word array, honouring byteenable.
//   It queues read bursts and returns them on readdata/readdatavalid after a fixed latency.

---
 rtl/amm_mem_responder.sv | 161 ++++++++++++++++
 tb/tb_amm_mem_responder.sv | 275 +++++++++++++++++++++++++++
 2 files changed

// File: rtl/amm_mem_responder.sv
// Avalon-MM burst slave backed by a word array: byte-enabled write bursts,
// queued read bursts returned after a fixed latency, optional LFSR-driven stalls.
//
// state   | meaning
// RD_IDLE | no burst active; picks up the cmd FIFO head when one is queued
// RD_WAIT | counting down so the first beat lands READ_LATENCY after acceptance
// RD_DATA | streaming the remaining beats of the active burst, one per cycle
module amm_mem_responder #(
  parameter int AMM_ADDR_W     = 32,
  parameter int AMM_DATA_W     = 64,
  parameter int AMM_BURST_W    = 11,
  parameter int MEM_ADDR_W     = 10,
  parameter int READ_LATENCY   = 4,
  parameter int CMD_FIFO_DEPTH = 4
) (
  input  logic                    clk_i,
  input  logic                    rst_i,
  input  logic [AMM_ADDR_W-1:0]   amm_address_i,
  input  logic                    amm_read_i,
  input  logic                    amm_write_i,
  input  logic [AMM_DATA_W-1:0]   amm_writedata_i,
  input  logic [AMM_DATA_W/8-1:0] amm_byteenable_i,
  input  logic [AMM_BURST_W-1:0]  amm_burstcount_i,
  output logic                    amm_waitrequest_o,
  output logic [AMM_DATA_W-1:0]   amm_readdata_o,
  output logic                    amm_readdatavalid_o,
  input  logic                    stall_en_i,
  output logic                    err_o
);

  localparam int BE_W  = AMM_DATA_W / 8;
  localparam int DEPTH = 2 ** MEM_ADDR_W;
  localparam int PTR_W = $clog2(CMD_FIFO_DEPTH);
  localparam int CNT_W = PTR_W + 1;
  localparam int LAT_W = $clog2(READ_LATENCY + 1);
  localparam int ENT_W = MEM_ADDR_W + AMM_BURST_W;

  typedef enum logic [1:0] {RD_IDLE, RD_WAIT, RD_DATA} rd_state_e;

  logic [AMM_DATA_W-1:0]  mem [DEPTH];
  logic [ENT_W-1:0]       fifo_mem [CMD_FIFO_DEPTH];
  logic [15:0]            lfsr;

  logic                   wr_open;
  logic [MEM_ADDR_W-1:0]  wr_addr;
  logic [AMM_BURST_W-1:0] wr_left;

  logic [PTR_W-1:0]       wr_ptr, rd_ptr;
  logic [CNT_W-1:0]       fifo_cnt;
  logic                   fifo_full, fifo_empty;

  rd_state_e              rd_state;
  logic [LAT_W-1:0]       lat_cnt;
  logic [MEM_ADDR_W-1:0]  rd_addr;
  logic [AMM_BURST_W-1:0] beats_left;

  logic accept_ok, wr_beat, rd_req, bc_zero, wr_drop, wr_do, push, pop;
  logic emit, last_beat, both_req, err_cond;
  logic [MEM_ADDR_W-1:0] wr_cur_addr;
  logic addr_hi_unused;

  assign addr_hi_unused = ^amm_address_i[AMM_ADDR_W-1:MEM_ADDR_W];

  assign fifo_full  = (fifo_cnt == CNT_W'(CMD_FIFO_DEPTH));
  assign fifo_empty = (fifo_cnt == '0);

  assign amm_waitrequest_o = !rst_i | fifo_full | (amm_read_i & wr_open)
                           | (stall_en_i & lfsr[0]);

  assign accept_ok   = !amm_waitrequest_o;
  assign bc_zero     = (amm_burstcount_i == '0);
  assign wr_beat     = accept_ok & amm_write_i;
  assign both_req    = accept_ok & amm_write_i & amm_read_i;
  assign rd_req      = accept_ok & amm_read_i & !amm_write_i;
  assign wr_drop     = wr_beat & !wr_open & bc_zero;
  assign wr_do       = wr_beat & !wr_drop;
  assign wr_cur_addr = wr_open ? wr_addr : amm_address_i[MEM_ADDR_W-1:0];
  assign push        = rd_req & !bc_zero;
  assign err_cond    = wr_drop | (rd_req & bc_zero) | both_req;

  // The active burst keeps its FIFO slot until its last beat, so FIFO depth
  // bounds the total number of outstanding read bursts.
  assign emit      = ((rd_state == RD_WAIT) && (lat_cnt == '0)) || (rd_state == RD_DATA);
  assign last_beat = emit && (beats_left == AMM_BURST_W'(1));
  assign pop       = last_beat;

  always_ff @(posedge clk_i) begin
    if (wr_do) begin
      for (int b = 0; b < BE_W; b++) begin
        if (amm_byteenable_i[b]) mem[wr_cur_addr][b*8 +: 8] <= amm_writedata_i[b*8 +: 8];
      end
    end
    if (push) fifo_mem[wr_ptr] <= {amm_address_i[MEM_ADDR_W-1:0], amm_burstcount_i};
  end

  always_ff @(posedge clk_i) begin
    if (!rst_i) begin
      lfsr                <= 16'hACE1;
      err_o               <= 1'b0;
      wr_open             <= 1'b0;
      wr_addr             <= '0;
      wr_left             <= '0;
      wr_ptr              <= '0;
      rd_ptr              <= '0;
      fifo_cnt            <= '0;
      rd_state            <= RD_IDLE;
      lat_cnt             <= '0;
      rd_addr             <= '0;
      beats_left          <= '0;
      amm_readdatavalid_o <= 1'b0;
      amm_readdata_o      <= '0;
    end else begin
      lfsr <= {lfsr[0] ^ lfsr[2] ^ lfsr[3] ^ lfsr[5], lfsr[15:1]};
      if (err_cond) err_o <= 1'b1;

      if (wr_do) begin
        if (!wr_open) begin
          wr_addr <= amm_address_i[MEM_ADDR_W-1:0] + 1'b1;
          wr_left <= amm_burstcount_i - 1'b1;
          wr_open <= (amm_burstcount_i != AMM_BURST_W'(1));
        end else begin
          wr_addr <= wr_addr + 1'b1;
          wr_left <= wr_left - 1'b1;
          wr_open <= (wr_left != AMM_BURST_W'(1));
        end
      end

      if (push) wr_ptr <= wr_ptr + 1'b1;
      if (pop)  rd_ptr <= rd_ptr + 1'b1;
      case ({push, pop})
        2'b10:   fifo_cnt <= fifo_cnt + 1'b1;
        2'b01:   fifo_cnt <= fifo_cnt - 1'b1;
        default: ;
      endcase

      amm_readdatavalid_o <= 1'b0;
      case (rd_state)
        RD_IDLE: begin
          if (!fifo_empty) begin
            {rd_addr, beats_left} <= fifo_mem[rd_ptr];
            lat_cnt               <= LAT_W'(READ_LATENCY - 2);
            rd_state              <= RD_WAIT;
          end
        end
        RD_WAIT: begin
          if (lat_cnt != '0) lat_cnt <= lat_cnt - 1'b1;
        end
        default: ;
      endcase

      if (emit) begin
        amm_readdata_o      <= mem[rd_addr];
        amm_readdatavalid_o <= 1'b1;
        rd_addr             <= rd_addr + 1'b1;
        beats_left          <= beats_left - 1'b1;
        rd_state            <= last_beat ? RD_IDLE : RD_DATA;
      end
    end
  end

endmodule

// File: tb/tb_amm_mem_responder.sv
// Scoreboard bench for amm_mem_responder: drivers push expected read beats,
// a negedge monitor pops and compares whenever readdatavalid is seen.
module tb_amm_mem_responder;

  localparam int LAT = 4;

  logic        clk = 1'b0;
  logic        rst_n;
  logic [31:0] addr;
  logic        rd, wr;
  logic [63:0] wdata;
  logic [7:0]  be;
  logic [10:0] bc;
  logic        wreq;
  logic [63:0] rdata;
  logic        rdv;
  logic        stall_en;
  logic        err;

  amm_mem_responder dut (
    .clk_i               (clk),
    .rst_i               (rst_n),
    .amm_address_i       (addr),
    .amm_read_i          (rd),
    .amm_write_i         (wr),
    .amm_writedata_i     (wdata),
    .amm_byteenable_i    (be),
    .amm_burstcount_i    (bc),
    .amm_waitrequest_o   (wreq),
    .amm_readdata_o      (rdata),
    .amm_readdatavalid_o (rdv),
    .stall_en_i          (stall_en),
    .err_o               (err)
  );

  always #5 clk = ~clk;

  int          total = 0;
  int          bad   = 0;
  int          cyc   = 0;
  logic [15:0] lf;
  logic [63:0] mem_m [1024];
  logic [63:0] exp_q [$];
  logic [63:0] wd [256];
  logic [7:0]  wb [256];
  bit          mon_ignore = 1'b0;
  logic [63:0] mon_e;

  // Reference LFSR: same polynomial as the stall generator, reloaded on reset.
  always @(posedge clk) begin
    cyc <= cyc + 1;
    if (!rst_n) lf <= 16'hACE1;
    else        lf <= {lf[0] ^ lf[2] ^ lf[3] ^ lf[5], lf[15:1]};
  end

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s actual=%h required=%h", name, act, exp);
    end
  endtask

  always @(negedge clk) begin
    if (rdv === 1'b1 && !mon_ignore) begin
      if (exp_q.size() == 0) begin
        total++;
        bad++;
        $display("FAIL unexpected_beat actual=%h required=none", rdata);
      end else begin
        mon_e = exp_q.pop_front();
        check("read_beat", rdata, mon_e);
      end
    end
  end

  task automatic write_burst(input int a, input int n, input bit gaps, input bit chk_w);
    int   beat  = 0;
    int   tries = 0;
    int   cur   = a;
    logic w;
    while (beat < n && tries < 4000) begin
      tries++;
      if (gaps && beat > 0 && $urandom_range(3) == 0) begin
        wr = 1'b0;
        @(posedge clk);
        @(negedge clk);
      end else begin
        wr = 1'b1; addr = a; bc = 11'(n); wdata = wd[beat]; be = wb[beat];
        #1;
        w = wreq;
        if (chk_w) check("wait_vs_lfsr_wr", {63'b0, w}, {63'b0, lf[0]});
        @(posedge clk);
        if (!w) begin
          for (int b = 0; b < 8; b++)
            if (wb[beat][b]) mem_m[cur % 1024][b*8 +: 8] = wd[beat][b*8 +: 8];
          cur++;
          beat++;
        end
        @(negedge clk);
      end
    end
    wr = 1'b0;
    if (beat < n) check("write_timeout", 64'(beat), 64'(n));
  endtask

  task automatic read_req(input int a, input int n, input bit push, input bit chk_w,
                          output int waits, output int acc);
    int   tries = 0;
    bit   done  = 1'b0;
    logic w;
    waits = 0;
    acc   = 0;
    while (!done && tries < 4000) begin
      tries++;
      rd = 1'b1; addr = a; bc = 11'(n);
      #1;
      w = wreq;
      if (chk_w && lf[0]) check("wait_vs_lfsr_rd", {63'b0, w}, 64'd1);
      acc = cyc + 1;
      @(posedge clk);
      if (!w) begin
        done = 1'b1;
        if (push) for (int i = 0; i < n; i++) exp_q.push_back(mem_m[(a + i) % 1024]);
      end else begin
        waits++;
      end
      @(negedge clk);
    end
    rd = 1'b0;
    if (!done) check("read_timeout", 64'd0, 64'd1);
  endtask

  task automatic wait_drain(input int budget);
    int n = 0;
    while (exp_q.size() != 0 && n < budget) begin
      @(negedge clk);
      n++;
    end
    if (exp_q.size() != 0) begin
      check("drain_timeout", 64'(exp_q.size()), 64'd0);
      exp_q.delete();
    end
  endtask

  initial begin
    #1_500_000;
    $display("FAIL watchdog actual=timeout required=finish");
    $fatal(1, "watchdog");
  end

  initial begin
    int waits, acc, n, run, a, nb;
    int w3 [5];
    rst_n = 1'b0; rd = 1'b0; wr = 1'b0; addr = '0; wdata = '0; be = '0; bc = '0;
    stall_en = 1'b0;
    repeat (3) @(negedge clk);
    check("rst_waitrequest", {63'b0, wreq}, 64'd1);
    check("rst_rdv",         {63'b0, rdv},  64'd0);
    check("rst_readdata",    rdata,         64'd0);
    check("rst_err",         {63'b0, err},  64'd0);
    rst_n = 1'b1;
    @(negedge clk);
    check("idle_waitrequest", {63'b0, wreq}, 64'd0);

    // 1: burst of 4 then readback with latency and back-to-back beats
    for (int i = 0; i < 4; i++) begin wd[i] = 64'(i + 1); wb[i] = 8'hFF; end
    write_burst(32'h10, 4, 1'b0, 1'b0);
    exp_q.push_back(64'd1); exp_q.push_back(64'd2);
    exp_q.push_back(64'd3); exp_q.push_back(64'd4);
    read_req(32'h10, 4, 1'b0, 1'b0, waits, acc);
    n = 0;
    while (rdv !== 1'b1 && n < 50) begin @(negedge clk); n++; end
    check("first_beat_latency", 64'(cyc - acc), 64'(LAT));
    run = 0;
    while (rdv === 1'b1 && run < 20) begin run++; @(negedge clk); end
    check("beat_run_length", 64'(run), 64'd4);
    wait_drain(100);

    // 2: byte enables
    wd[0] = 64'hFFFF_FFFF_FFFF_FFFF; wb[0] = 8'hFF;
    write_burst(32'h20, 1, 1'b0, 1'b0);
    wd[0] = 64'h0; wb[0] = 8'h0F;
    write_burst(32'h20, 1, 1'b0, 1'b0);
    exp_q.push_back(64'hFFFF_FFFF_0000_0000);
    read_req(32'h20, 1, 1'b0, 1'b0, waits, acc);
    wait_drain(100);

    // 3: one more read burst than the FIFO holds
    for (int i = 0; i < 40; i++) begin wd[i] = 64'h3000 + 64'(i); wb[i] = 8'hFF; end
    write_burst(32'h100, 40, 1'b0, 1'b0);
    for (int j = 0; j < 5; j++) begin
      read_req(32'h100 + 32'(8 * j), 8, 1'b1, 1'b0, waits, acc);
      w3[j] = waits;
    end
    check("fifo_room_no_stall", 64'(w3[0] + w3[1] + w3[2] + w3[3]), 64'd0);
    check("fifo_full_stall", {63'b0, w3[4] != 0}, 64'd1);
    wait_drain(500);

    // 4: address wrap at the top of the array
    for (int i = 0; i < 4; i++) begin wd[i] = 64'hA0 + 64'(i); wb[i] = 8'hFF; end
    write_burst(1022, 4, 1'b0, 1'b0);
    exp_q.push_back(64'hA0); exp_q.push_back(64'hA1);
    exp_q.push_back(64'hA2); exp_q.push_back(64'hA3);
    read_req(1022, 4, 1'b0, 1'b0, waits, acc);
    exp_q.push_back(64'hA2); exp_q.push_back(64'hA3);
    read_req(0, 2, 1'b0, 1'b0, waits, acc);
    wait_drain(100);

    // 5: random traffic under LFSR stalls
    stall_en = 1'b1;
    for (int i = 0; i < 128; i++) begin wd[i] = {$urandom, $urandom}; wb[i] = 8'hFF; end
    write_burst(32'h200, 128, 1'b0, 1'b1);
    for (int op = 0; op < 1000; op++) begin
      nb = $urandom_range(8, 1);
      a  = 32'h200 + $urandom_range(119, 0);
      if ($urandom_range(1, 0) == 1) begin
        wait_drain(300);
        for (int i = 0; i < nb; i++) begin wd[i] = {$urandom, $urandom}; wb[i] = 8'($urandom); end
        write_burst(a, nb, 1'b1, 1'b1);
      end else begin
        read_req(a, nb, 1'b1, 1'b1, waits, acc);
      end
    end
    wait_drain(500);
    check("random_err_clear", {63'b0, err}, 64'd0);
    stall_en = 1'b0;

    // 6: reset mid-burst, then protocol errors
    for (int i = 0; i < 8; i++) begin wd[i] = 64'h600 + 64'(i); wb[i] = 8'hFF; end
    write_burst(32'h300, 8, 1'b0, 1'b0);
    mon_ignore = 1'b1;
    read_req(32'h300, 8, 1'b0, 1'b0, waits, acc);
    n = 0;
    while (rdv !== 1'b1 && n < 50) begin @(negedge clk); n++; end
    @(negedge clk);
    rst_n = 1'b0;
    @(negedge clk);
    check("midburst_rst_rdv",  {63'b0, rdv},  64'd0);
    check("midburst_rst_wreq", {63'b0, wreq}, 64'd1);
    rst_n = 1'b1;
    mon_ignore = 1'b0;
    run = 0;
    for (int i = 0; i < 20; i++) begin @(negedge clk); if (rdv === 1'b1) run++; end
    check("no_beats_after_rst", 64'(run), 64'd0);
    check("err_after_rst", {63'b0, err}, 64'd0);

    rd = 1'b1; addr = 32'h40; bc = 11'd0;
    @(posedge clk); @(negedge clk);
    rd = 1'b0;
    repeat (10) @(negedge clk);
    check("err_read_bc0", {63'b0, err}, 64'd1);

    rst_n = 1'b0; @(negedge clk); rst_n = 1'b1; @(negedge clk);
    wr = 1'b1; addr = 32'h40; bc = 11'd0; wdata = 64'h1; be = 8'hFF;
    @(posedge clk); @(negedge clk);
    wr = 1'b0;
    check("err_write_bc0", {63'b0, err}, 64'd1);

    rst_n = 1'b0; @(negedge clk); rst_n = 1'b1; @(negedge clk);
    rd = 1'b1; wr = 1'b1; addr = 32'h10; bc = 11'd1; wdata = 64'h55; be = 8'hFF;
    @(posedge clk); @(negedge clk);
    rd = 1'b0; wr = 1'b0;
    check("err_rd_wr_same_cycle", {63'b0, err}, 64'd1);
    repeat (10) @(negedge clk);
    exp_q.push_back(64'h55);
    read_req(32'h10, 1, 1'b0, 1'b0, waits, acc);
    wait_drain(100);
    repeat (5) @(negedge clk);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
